// File: rtl/prog_counter_gen_if.sv
// prog_counter_gen_if: control, bus and status signals of the program counter.
interface prog_counter_gen_if #(parameter int WIDTH = 8);
    logic             en;
    logic             load;
    logic             oe;
    logic             dir;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_out;
    logic [WIDTH-1:0] bus_oe;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    modport master (output en, load, oe, dir, bus_in, input bus_out, bus_oe, count, tc, busy);
    modport slave (input en, load, oe, dir, bus_in, output bus_out, bus_oe, count, tc, busy);
endinterface

// File: rtl/prog_counter_gen.sv
// prog_counter_gen: bus-loadable WIDTH-bit program counter with release/capture handshake.
// Define PC_DOWN_COUNT_EN to honour dir and include down-counting with underflow wrap.
module prog_counter_gen #(
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] MAX            = {WIDTH{1'b1}},
    parameter int               RELEASE_CYCLES = 1
) (
    input logic             clk,
    input logic             rst,
    prog_counter_gen_if.slave bus
);
    typedef enum logic [1:0] {DRIVE = 2'd0, RELEASE = 2'd1, CAPTURE = 2'd2} state_t;
    state_t           state;
    logic             en_q, load_q, oe_q, load_prev, tc, wrap, load_pulse;
    logic [3:0]       rel_cnt;
    logic [WIDTH-1:0] count, step;
    assign load_pulse = load_q & ~load_prev;
`ifdef PC_DOWN_COUNT_EN
    logic dir_q;
    always_ff @(posedge clk) dir_q <= rst ? 1'b0 : bus.dir;
    assign wrap = dir_q ? (count == '0) : (count == MAX);
    assign step = wrap ? (dir_q ? MAX : '0) : (dir_q ? count - 1'b1 : count + 1'b1);
`else
    logic unused_dir;
    assign unused_dir = bus.dir;
    assign wrap = count == MAX;
    assign step = wrap ? '0 : count + 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DRIVE;
            count     <= '0;
            tc        <= 1'b0;
            rel_cnt   <= '0;
            en_q      <= 1'b0;
            load_q    <= 1'b0;
            oe_q      <= 1'b0;
            load_prev <= 1'b0;
        end else begin
            en_q      <= bus.en;
            load_q    <= bus.load;
            oe_q      <= bus.oe;
            load_prev <= load_q;
            tc        <= 1'b0;
            case (state)
                DRIVE: begin
                    if (load_pulse) begin
                        state   <= RELEASE;
                        rel_cnt <= 4'(RELEASE_CYCLES - 1);
                    end
                    if (en_q) begin
                        count <= step;
                        tc    <= wrap;
                    end
                end
                RELEASE: begin
                    if (rel_cnt == '0) state <= CAPTURE;
                    else rel_cnt <= rel_cnt - 1'b1;
                end
                CAPTURE: begin
                    count <= (bus.bus_in > MAX) ? MAX : bus.bus_in;
                    state <= DRIVE;
                end
                default: state <= DRIVE;
            endcase
        end
    end
    assign bus.count   = count;
    assign bus.bus_out = count;
    assign bus.tc      = tc;
    assign bus.busy    = state != DRIVE;
    assign bus.bus_oe  = {WIDTH{(state == DRIVE) & oe_q}};
endmodule
